// File: rtl/decoder_pkg.sv
// Shared types, mode constants and the code-to-select decode function for decoder_pipe.
package decoder_pkg;

   // Widest select word the decode function can produce; N_OUT must not exceed it.
   localparam int unsigned DEC_MAX_OUT = 64;

   localparam logic DEC_MODE_ONEHOT = 1'b0;
   localparam logic DEC_MODE_THERMO = 1'b1;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_t;

   // Returns {err, sel[DEC_MAX_OUT-1:0]}; only the low n_out select bits can ever be set.
   function automatic logic [DEC_MAX_OUT:0] dec_word(input int unsigned code,
                                                     input logic        en,
                                                     input logic        mode,
                                                     input int unsigned n_out);
      logic [DEC_MAX_OUT:0] w;
      w = '0;
      if (en) begin
         if (code >= n_out) begin
            w[DEC_MAX_OUT] = 1'b1;
         end else begin
            for (int unsigned i = 0; i < DEC_MAX_OUT; i++) begin
               if (i == code || (mode == DEC_MODE_THERMO && i < code)) begin
                  w[i] = 1'b1;
               end
            end
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/decoder_skid.sv
// Generic W-bit two-entry skid buffer (output register + one skid slot), registered ready/valid.
module decoder_skid
   import decoder_pkg::*;
#(
   parameter int unsigned W = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   skid_state_t  state;
   skid_state_t  state_nxt;
   logic [W-1:0] skid_data;
   logic         in_xfer_c;
   logic         out_xfer_c;
   logic         out_load_c;
   logic         out_from_skid_c;
   logic         skid_load_c;

   assign in_xfer_c  = in_valid & in_ready;
   assign out_xfer_c = out_valid & out_ready;

   // Next state and data-path steering
   always_comb begin
      state_nxt       = state;
      out_load_c      = 1'b0;
      out_from_skid_c = 1'b0;
      skid_load_c     = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (in_xfer_c) begin
               out_load_c = 1'b1;
               state_nxt  = ST_ONE;
            end
         end
         ST_ONE: begin
            if (in_xfer_c && out_xfer_c) begin
               out_load_c = 1'b1;
            end else if (in_xfer_c) begin
               skid_load_c = 1'b1;
               state_nxt   = ST_FULL;
            end else if (out_xfer_c) begin
               state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (out_xfer_c) begin
               out_load_c      = 1'b1;
               out_from_skid_c = 1'b1;
               state_nxt       = ST_ONE;
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   // Handshake flags are registered from the next state so ready never sees out_ready combinationally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         skid_data <= '0;
      end else begin
         state     <= state_nxt;
         in_ready  <= (state_nxt != ST_FULL);
         out_valid <= (state_nxt != ST_EMPTY);
         if (out_load_c) begin
            out_data <= out_from_skid_c ? skid_data : in_data;
         end
         if (skid_load_c) begin
            skid_data <= in_data;
         end
      end
   end

endmodule

// File: rtl/decoder_pipe.sv
// Pipelined binary-to-select decoder with valid/ready on both sides and out-of-range flagging.
// Thermometer mode and the in_mode port exist only when DECODER_THERMO_EN is defined.
module decoder_pipe
   import decoder_pkg::*;
#(
   parameter int unsigned IN_W  = 3,
   parameter int unsigned N_OUT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_code,
   input  logic             in_en,
`ifdef DECODER_THERMO_EN
   input  logic             in_mode,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N_OUT-1:0] out_sel,
   output logic             out_err
);

   localparam int unsigned SKID_W = N_OUT + 1;

   logic                 mode_c;
   logic [DEC_MAX_OUT:0] dec_full_c;
   logic [SKID_W-1:0]    skid_in_c;
   logic [SKID_W-1:0]    skid_out;

`ifdef DECODER_THERMO_EN
   assign mode_c = in_mode;
`else
   assign mode_c = DEC_MODE_ONEHOT;
`endif

   // Decode ahead of the buffer so stored words already carry sel and err
   assign dec_full_c = dec_word(32'(in_code), in_en, mode_c, N_OUT);
   assign skid_in_c  = {dec_full_c[DEC_MAX_OUT], dec_full_c[N_OUT-1:0]};

   // Select bits above N_OUT are always zero from dec_word
   if (N_OUT < DEC_MAX_OUT) begin : g_spare
      logic [DEC_MAX_OUT-N_OUT-1:0] dec_unused;
      assign dec_unused = dec_full_c[DEC_MAX_OUT-1:N_OUT];
   end

   decoder_skid #(
      .W (SKID_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (skid_in_c),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (skid_out)
   );

   assign out_sel = skid_out[N_OUT-1:0];
   assign out_err = skid_out[N_OUT];

endmodule

// File: tb/tb_decoder_pipe.sv
// Randomized and directed bench for decoder_pipe (N_OUT=8 and N_OUT=6 instances sharing stimulus).
module tb_decoder_pipe;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [2:0] in_code;
   logic       in_en;
`ifdef DECODER_THERMO_EN
   logic       in_mode;
`endif
   logic       out_ready;
   logic       in_ready,  in_ready6;
   logic       out_valid, out_valid6;
   logic [7:0] out_sel;
   logic [5:0] out_sel6;
   logic       out_err,   out_err6;

   always #5 clk = ~clk;

   decoder_pipe #(.IN_W(3), .N_OUT(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_code(in_code), .in_en(in_en),
`ifdef DECODER_THERMO_EN
      .in_mode(in_mode),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel), .out_err(out_err)
   );

   decoder_pipe #(.IN_W(3), .N_OUT(6)) dut6 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready6),
      .in_code(in_code), .in_en(in_en),
`ifdef DECODER_THERMO_EN
      .in_mode(in_mode),
`endif
      .out_valid(out_valid6), .out_ready(out_ready), .out_sel(out_sel6), .out_err(out_err6)
   );

   typedef struct {
      int sel8;
      bit err8;
      int sel6;
      bit err6;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_steps  = 0;
   bit   ordy;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic int ref_sel(input int code, input bit en, input bit mode, input int n);
      if (!en || code >= n) return 0;
      return mode ? ((1 << (code + 1)) - 1) : (1 << code);
   endfunction

   function automatic exp_t ref_word(input int code, input bit en, input bit mode);
      exp_t e;
      bit   m;
`ifdef DECODER_THERMO_EN
      m = mode;
`else
      m = 1'b0;
`endif
      e.sel8 = ref_sel(code, en, m, 8);
      e.err8 = en && code >= 8;
      e.sel6 = ref_sel(code, en, m, 6);
      e.err6 = en && code >= 6;
      return e;
   endfunction

   task automatic compare_outputs();
      check("in_ready",   32'(in_ready),   32'(q.size() < 2));
      check("in_ready6",  32'(in_ready6),  32'(q.size() < 2));
      check("out_valid",  32'(out_valid),  32'(q.size() > 0));
      check("out_valid6", 32'(out_valid6), 32'(q.size() > 0));
      if (q.size() > 0) begin
         check("sel8", 32'(out_sel),  32'(q[0].sel8));
         check("err8", 32'(out_err),  32'(q[0].err8));
         check("sel6", 32'(out_sel6), 32'(q[0].sel6));
         check("err6", 32'(out_err6), 32'(q[0].err6));
      end
   endtask

   // One clock: check outputs at negedge, drive inputs, advance the model past the next posedge
   task automatic step(input bit v, input int code, input bit en, input bit m, output bit acc);
      @(negedge clk);
      compare_outputs();
      in_valid  = v;
      in_code   = 3'(code);
      in_en     = en;
`ifdef DECODER_THERMO_EN
      in_mode   = m;
`endif
      out_ready = ordy;
      acc = v && (q.size() < 2);
      if (ordy && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(ref_word(code, en, m));
      n_steps++;
   endtask

   task automatic send(input int code, input bit en, input bit m);
      bit acc = 1'b0;
      for (int i = 0; i < 40 && !acc; i++) step(1'b1, code, en, m, acc);
      if (!acc) check("send_timeout", 32'(0), 32'(1));
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, acc);
   endtask

   task automatic peek();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int  t0;
      bit  acc;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_code   = '0;
      in_en     = 1'b0;
`ifdef DECODER_THERMO_EN
      in_mode   = 1'b0;
`endif
      out_ready = 1'b0;
      ordy      = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_valid", 32'(out_valid), 32'(0));
      check("rst_ready", 32'(in_ready),  32'(1));
      check("rst_sel",   32'(out_sel),   32'(0));
      check("rst_err",   32'(out_err),   32'(0));
      rst = 1'b0;

      // Full-rate sweep of codes 0..7
      ordy = 1'b1;
      t0 = n_steps;
      for (int c = 0; c < 8; c++) send(c, 1'b1, 1'b0);
      check("sweep_clks", 32'(n_steps - t0), 32'(8));
      peek();
      check("sweep_last_sel", 32'(out_sel), 32'h80);

      // Disabled decode still yields a valid empty word
      send(5, 1'b0, 1'b0);
      peek();
      check("en0_sel",   32'(out_sel),   32'h00);
      check("en0_err",   32'(out_err),   32'(0));
      check("en0_valid", 32'(out_valid), 32'(1));

      // Range errors on the N_OUT=6 instance
      send(6, 1'b1, 1'b0);
      peek();
      check("n6_c6_sel", 32'(out_sel6), 32'h00);
      check("n6_c6_err", 32'(out_err6), 32'(1));
      send(7, 1'b1, 1'b0);
      peek();
      check("n6_c7_err", 32'(out_err6), 32'(1));
      check("n8_c7_sel", 32'(out_sel),  32'h80);
      send(5, 1'b1, 1'b0);
      peek();
      check("n6_c5_sel", 32'(out_sel6), 32'h20);
      check("n6_c5_err", 32'(out_err6), 32'(0));
      idle(2);

      // Backpressure: 3,4 fill both entries, 5 waits, then all drain in order
      ordy = 1'b0;
      send(3, 1'b1, 1'b0);
      send(4, 1'b1, 1'b0);
      step(1'b1, 5, 1'b1, 1'b0, acc);
      check("bp_5_refused", 32'(acc), 32'(0));
      peek();
      check("bp_ready_low", 32'(in_ready), 32'(0));
      check("bp_hold_sel",  32'(out_sel),  32'h08);
      ordy = 1'b1;
      send(5, 1'b1, 1'b0);
      idle(4);

      // Asynchronous reset while full
      ordy = 1'b0;
      send(1, 1'b1, 1'b0);
      send(2, 1'b1, 1'b0);
      @(negedge clk);
      compare_outputs();
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("rstfull_valid", 32'(out_valid), 32'(0));
      check("rstfull_ready", 32'(in_ready),  32'(1));
      q.delete();
      @(negedge clk);
      rst  = 1'b0;
      ordy = 1'b1;
      send(6, 1'b1, 1'b0);
      peek();
      check("post_rst_sel", 32'(out_sel), 32'h40);
      idle(2);

`ifdef DECODER_THERMO_EN
      send(3, 1'b1, 1'b1);
      peek();
      check("thermo3", 32'(out_sel), 32'h0F);
      send(7, 1'b1, 1'b1);
      peek();
      check("thermo7", 32'(out_sel), 32'hFF);
      send(3, 1'b1, 1'b0);
      peek();
      check("onehot3", 32'(out_sel), 32'h08);
      idle(2);
`endif

      // Random traffic against the queue model
      for (int i = 0; i < 3000; i++) begin
         ordy = ($urandom_range(0, 3) != 0);
         step($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
              $urandom_range(0, 5) != 0, 1'($urandom_range(0, 1)), acc);
      end
      ordy = 1'b1;
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
